dmem_arbiter: RTL and testbench

- Two-requester arbiter/sequencer in front of the word-aligned data memory (32-bit words, byte addresses, combinational read, write on posedge clk).
- Port 0 is the CPU load/store unit; port 1 is the debug/DMA loader.
- Grants one access at a time, round-robin on contention; drives the memory's address/data/enable inputs from registered state.
- Returns read data to the winner through a registered response.

---
 rtl/dmem_arbiter.sv | 164 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin arbiter in front of the word-aligned data memory.
// Port 0 is the CPU load/store unit and port 1 is the debug/DMA loader.
// An access takes one IDLE cycle to arbitrate and latch the request, then one ACCESS
// cycle that drives the memory from registered state. Read data returns one cycle later.
// Optional build macro DMEM_ARB_ALIGN_CHECK_EN: misaligned accesses are granted but
// suppressed at the memory, flagged with m<n>_err, and misaligned reads return zero.

module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_err,

  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_err,

  output logic [ADDR_W-1:0] mem_access_addr,
  output logic [DATA_W-1:0] mem_in,
  output logic              mem_write_en,
  output logic              mem_read_en,
  input  logic [DATA_W-1:0] mem_out,

  output logic [CNT_W-1:0]  conflict_cnt
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;

  // Winner of the most recent arbitration; resets to 1 so port 0 wins the first tie.
  logic              last_grant;

  // Request captured in IDLE and replayed to memory during ACCESS.
  logic              sel_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic              take;
  logic              sel_nxt;
  logic              in_access;
  logic              misaligned;
  logic              rd_fire;
  logic [DATA_W-1:0] rd_data;

`ifdef DMEM_ARB_ALIGN_CHECK_EN
  assign misaligned = (addr_q[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // State register: IDLE after reset, otherwise follow the next-state logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Arbitration and sequencing: pick a winner in IDLE, always leave ACCESS after one cycle.
  always_comb begin
    state_nxt = state;
    sel_nxt   = sel_q;
    take      = 1'b0;
    case (state)
      IDLE: begin
        if (m0_req || m1_req) begin
          take      = 1'b1;
          sel_nxt   = (m0_req && m1_req) ? ~last_grant : m1_req;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Memory strobes, grants and error pulses come only from registered state.
  always_comb begin
    in_access       = (state == ACCESS);
    mem_access_addr = addr_q;
    mem_in          = wdata_q;
    mem_write_en    = in_access & we_q & ~misaligned;
    mem_read_en     = in_access & ~we_q & ~misaligned;
    m0_gnt          = in_access & ~sel_q;
    m1_gnt          = in_access & sel_q;
    m0_err          = in_access & ~sel_q & misaligned;
    m1_err          = in_access & sel_q & misaligned;
    rd_fire         = in_access & ~we_q;
    rd_data         = misaligned ? '0 : mem_out;
  end

  // Latch the winning request and remember who won for the next tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      sel_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else if (take) begin
      last_grant <= sel_nxt;
      sel_q      <= sel_nxt;
      we_q       <= sel_nxt ? m1_we    : m0_we;
      addr_q     <= sel_nxt ? m1_addr  : m0_addr;
      wdata_q    <= sel_nxt ? m1_wdata : m0_wdata;
    end
  end

  // Read response: capture memory data at the end of ACCESS and pulse rvalid for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
    end else begin
      m0_rvalid <= rd_fire & ~sel_q;
      m1_rvalid <= rd_fire & sel_q;
      if (rd_fire && !sel_q) begin
        m0_rdata <= rd_data;
      end
      if (rd_fire && sel_q) begin
        m1_rdata <= rd_data;
      end
    end
  end

  // Saturating count of IDLE cycles in which both ports were requesting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt <= '0;
    end else if ((state == IDLE) && m0_req && m1_req && (conflict_cnt != '1)) begin
      conflict_cnt <= conflict_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: randomized scoreboard bench for dmem_arbiter.
// A transaction-level model predicts grant order, memory contents, read data and the
// contention count. A separate monitor compares the DUT outputs every cycle.

module tb_dmem_arbiter;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = 15;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] mem_access_addr, mem_in, mem_out;
  logic        mem_write_en, mem_read_en;
  logic [CNT_W-1:0] conflict_cnt;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_access_addr(mem_access_addr), .mem_in(mem_in),
    .mem_write_en(mem_write_en), .mem_read_en(mem_read_en), .mem_out(mem_out),
    .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  // Cycle counter: number of rising edges so far, read at falling edges.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural data memory: 16 words, ignores addr[1:0] and upper bits.
  logic [31:0] tb_mem [16];
  logic        mem_load;
  assign mem_out = tb_mem[mem_access_addr[5:2]];
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 16; i++) tb_mem[i] <= 32'hA000_0000 + 32'(i);
    end else if (mem_write_en) begin
      tb_mem[mem_access_addr[5:2]] <= mem_in;
    end
  end

  typedef struct { bit we; logic [31:0] addr; logic [31:0] wdata; } op_t;
  typedef struct { int cyc; int port; bit we; logic [31:0] addr; logic [31:0] wdata; bit err; } gnt_exp_t;
  typedef struct { int cyc; int port; logic [31:0] data; } rv_exp_t;
  typedef struct { int cyc; int val; } cnt_exp_t;

  gnt_exp_t gq[$];
  rv_exp_t  rvq[$];
  cnt_exp_t cq[$];
  op_t      plan0[$];
  op_t      plan1[$];

  // Reference model state.
  logic [31:0] model_mem [16];
  int          last_win;
  int          exp_cnt;
  int          next_free;
  bit          busy [2];
  int          gcyc [2];
  bit          cur_we [2];
  logic [31:0] cur_addr [2];
  logic [31:0] cur_wdata [2];
  logic [31:0] held [2];

  int  pass_cnt = 0;
  int  total_cnt = 0;
  bit  mon_en = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
  endtask

  task automatic pushOp(input int p, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
    op_t o;
    o.we = we; o.addr = addr; o.wdata = wdata;
    if (p == 0) plan0.push_back(o);
    else plan1.push_back(o);
  endtask

  task automatic driveInputs();
    m0_req = busy[0]; m0_we = cur_we[0]; m0_addr = cur_addr[0]; m0_wdata = cur_wdata[0];
    m1_req = busy[1]; m1_we = cur_we[1]; m1_addr = cur_addr[1]; m1_wdata = cur_wdata[1];
  endtask

  // Transaction-level model: the arbiter can accept one request every two cycles;
  // ties go to the port that did not win last; effects are predicted with cycle stamps.
  task automatic modelStep();
    gnt_exp_t g;
    rv_exp_t  r;
    cnt_exp_t c;
    int       w;
    int       idx;
    if (cyc >= next_free) begin
      if (busy[0] && busy[1]) exp_cnt = (exp_cnt < CNT_MAX) ? exp_cnt + 1 : CNT_MAX;
      if (busy[0] || busy[1]) begin
        w = (busy[0] && busy[1]) ? 1 - last_win : (busy[0] ? 0 : 1);
        last_win  = w;
        gcyc[w]   = cyc + 1;
        next_free = cyc + 2;
        idx = int'(cur_addr[w][5:2]);
        g.cyc = cyc + 1; g.port = w; g.we = cur_we[w]; g.addr = cur_addr[w];
        g.wdata = cur_wdata[w]; g.err = ALIGN && (cur_addr[w][1:0] != 2'b00);
        gq.push_back(g);
        if (cur_we[w]) begin
          if (!g.err) model_mem[idx] = cur_wdata[w];
        end else begin
          r.cyc = cyc + 2; r.port = w; r.data = g.err ? 32'h0 : model_mem[idx];
          rvq.push_back(r);
        end
      end
    end
    c.cyc = cyc + 1; c.val = exp_cnt;
    cq.push_back(c);
  endtask

  task automatic applyStimulus(input int ncycles, input bit rand_en);
    op_t o;
    bit  take;
    for (int k = 0; k < ncycles; k++) begin
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        if (busy[p] && gcyc[p] == cyc) busy[p] = 1'b0;
        if (!busy[p]) begin
          take = 1'b0;
          if (p == 0 && plan0.size() > 0) begin
            o = plan0.pop_front(); take = 1'b1;
          end else if (p == 1 && plan1.size() > 0) begin
            o = plan1.pop_front(); take = 1'b1;
          end else if (rand_en && $urandom_range(0, 2) != 0) begin
            o.we = 1'($urandom_range(0, 1));
            o.addr = 32'($urandom_range(0, 255));
            o.wdata = $urandom;
            take = 1'b1;
          end
          if (take) begin
            busy[p] = 1'b1; gcyc[p] = -1;
            cur_we[p] = o.we; cur_addr[p] = o.addr; cur_wdata[p] = o.wdata;
          end
        end
      end
      driveInputs();
      modelStep();
    end
  endtask

  task automatic resetModel();
    last_win = 1; exp_cnt = 0; next_free = 0;
    for (int p = 0; p < 2; p++) begin
      busy[p] = 1'b0; gcyc[p] = -1; cur_we[p] = 1'b0; cur_addr[p] = '0; cur_wdata[p] = '0;
    end
    gq.delete(); rvq.delete(); cq.delete(); plan0.delete(); plan1.delete();
  endtask

  task automatic monitorCycle();
    gnt_exp_t g;
    rv_exp_t  r;
    cnt_exp_t c;
    if (gq.size() > 0 && gq[0].cyc == cyc) begin
      g = gq.pop_front();
      checkOutput("m0_gnt", 64'(m0_gnt), 64'(g.port == 0));
      checkOutput("m1_gnt", 64'(m1_gnt), 64'(g.port == 1));
      checkOutput("m0_err", 64'(m0_err), 64'(g.port == 0 && g.err));
      checkOutput("m1_err", 64'(m1_err), 64'(g.port == 1 && g.err));
      checkOutput("mem_write_en", 64'(mem_write_en), 64'(g.we && !g.err));
      checkOutput("mem_read_en", 64'(mem_read_en), 64'(!g.we && !g.err));
      checkOutput("mem_access_addr", 64'(mem_access_addr), 64'(g.addr));
      checkOutput("mem_in", 64'(mem_in), 64'(g.wdata));
    end else begin
      checkOutput("quiet_gnt_mem", 64'({m0_gnt, m1_gnt, m0_err, m1_err, mem_write_en, mem_read_en}), 64'h0);
    end
    if (rvq.size() > 0 && rvq[0].cyc == cyc) begin
      r = rvq.pop_front();
      held[r.port] = r.data;
      checkOutput("m0_rvalid", 64'(m0_rvalid), 64'(r.port == 0));
      checkOutput("m1_rvalid", 64'(m1_rvalid), 64'(r.port == 1));
    end else begin
      checkOutput("quiet_rvalid", 64'({m0_rvalid, m1_rvalid}), 64'h0);
    end
    checkOutput("m0_rdata", 64'(m0_rdata), 64'(held[0]));
    checkOutput("m1_rdata", 64'(m1_rdata), 64'(held[1]));
    if (cq.size() > 0 && cq[0].cyc == cyc) begin
      c = cq.pop_front();
      checkOutput("conflict_cnt", 64'(conflict_cnt), 64'(c.val));
    end
  endtask

  // Monitor: read-data history clears under reset, otherwise score every cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      held[0] = 32'h0;
      held[1] = 32'h0;
    end else if (mon_en) begin
      monitorCycle();
    end
  end

  // Reset asserted during the ACCESS cycle of a write, before its committing edge.
  task automatic resetMidWrite();
    applyStimulus(6, 1'b0);
    mon_en = 1'b0;
    @(negedge clk);
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h10; m0_wdata = 32'h1234_5678;
    @(negedge clk);
    checkOutput("rst_pre_gnt", 64'(m0_gnt), 64'h1);
    checkOutput("rst_pre_we", 64'(mem_write_en), 64'h1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_we_drop", 64'(mem_write_en), 64'h0);
    checkOutput("rst_gnt_drop", 64'({m0_gnt, m1_gnt, m0_err, m1_err, mem_read_en}), 64'h0);
    checkOutput("rst_rdata0", 64'(m0_rdata), 64'h0);
    checkOutput("rst_rdata1", 64'(m1_rdata), 64'h0);
    checkOutput("rst_cnt", 64'(conflict_cnt), 64'h0);
    checkOutput("rst_addr", 64'(mem_access_addr), 64'h0);
    m0_req = 1'b0; m0_we = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rst_mem_kept", 64'(tb_mem[4]), 64'(model_mem[4]));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    resetModel();
    mon_en = 1'b1;
    applyStimulus(4, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; mem_load = 1'b1;
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
    for (int i = 0; i < 16; i++) model_mem[i] = 32'hA000_0000 + 32'(i);
    resetModel();
    repeat (3) @(negedge clk);
    checkOutput("reset_strobes", 64'({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err, mem_write_en, mem_read_en}), 64'h0);
    checkOutput("reset_rdata0", 64'(m0_rdata), 64'h0);
    checkOutput("reset_rdata1", 64'(m1_rdata), 64'h0);
    checkOutput("reset_mem_in", 64'(mem_in), 64'h0);
    checkOutput("reset_addr", 64'(mem_access_addr), 64'h0);
    checkOutput("reset_cnt", 64'(conflict_cnt), 64'h0);
    mem_load = 1'b0;
    rst_n = 1'b1;
    mon_en = 1'b1;

    $display("[TB] port 0 write then read of 0x8");
    pushOp(0, 1'b1, 32'h8, 32'hDEAD_BEEF);
    pushOp(0, 1'b0, 32'h8, 32'h0);
    applyStimulus(8, 1'b0);

    $display("[TB] both ports reading continuously");
    for (int i = 0; i < 4; i++) begin
      pushOp(0, 1'b0, 32'(4 * i), 32'h0);
      pushOp(1, 1'b0, 32'(4 * i + 16), 32'h0);
    end
    applyStimulus(20, 1'b0);

    $display("[TB] port 1 back-to-back reads");
    pushOp(1, 1'b0, 32'h0, 32'h0);
    pushOp(1, 1'b0, 32'h4, 32'h0);
    applyStimulus(8, 1'b0);

    $display("[TB] misaligned write to 0x6 then read of word 1");
    pushOp(0, 1'b1, 32'h6, 32'hCAFE_F00D);
    pushOp(0, 1'b0, 32'h4, 32'h0);
    pushOp(1, 1'b0, 32'h5, 32'h0);
    applyStimulus(10, 1'b0);

    $display("[TB] contention counter saturation");
    for (int i = 0; i < 20; i++) begin
      pushOp(0, 1'b0, 32'(4 * (i % 16)), 32'h0);
      pushOp(1, 1'b1, 32'(4 * ((i + 3) % 16)), $urandom);
    end
    applyStimulus(50, 1'b0);

    $display("[TB] randomized traffic");
    applyStimulus(400, 1'b1);

    $display("[TB] reset during ACCESS write");
    resetMidWrite();

    $display("[TB] randomized traffic after reset");
    applyStimulus(200, 1'b1);
    applyStimulus(8, 1'b0);

    $display("[TB] %0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
